// File: rtl/mips_cpu_pkg.sv
// Shared types for the writeback stage: request kinds, MIPS load opcodes and FSM states.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_LINK = 2'd2,
        WB_RSVD = 2'd3
    } wb_kind_t;

    typedef enum logic [2:0] {
        LT_LB   = 3'b000,
        LT_LH   = 3'b001,
        LT_LWL  = 3'b010,
        LT_LW   = 3'b011,
        LT_LBU  = 3'b100,
        LT_LHU  = 3'b101,
        LT_LWR  = 3'b110,
        LT_RSVD = 3'b111
    } load_type_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } wb_state_t;

endpackage

// File: rtl/mips_cpu_load_extract.sv
// Little-endian MIPS sub-word load extraction, including the LWL/LWR merge with the old rt value.
module mips_cpu_load_extract
    import mips_cpu_pkg::*;
(
    input  logic [31:0] rdata,
    input  load_type_t  load_type,
    input  logic [1:0]  byte_off,
    input  logic [31:0] old_rt,
    output logic [31:0] value
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [4:0]  lsh;
    logic [4:0]  rsh;

    assign sel_byte = rdata[{byte_off, 3'b000} +: 8];
    assign sel_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
    // 8*(3-k) equals {~k,000} for a two-bit k
    assign lsh      = {~byte_off, 3'b000};
    assign rsh      = {byte_off, 3'b000};

    always_comb begin
        value = rdata;
        case (load_type)
            LT_LB:   value = {{24{sel_byte[7]}}, sel_byte};
            LT_LBU:  value = {24'h000000, sel_byte};
            LT_LH:   value = {{16{sel_half[15]}}, sel_half};
            LT_LHU:  value = {16'h0000, sel_half};
            LT_LW:   value = rdata;
            LT_LWL:  value = (rdata << lsh) | (old_rt & ~(32'hFFFF_FFFF << lsh));
            LT_LWR:  value = (rdata >> rsh) | (old_rt & ~(32'hFFFF_FFFF >> rsh));
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/mips_cpu_writeback.sv
// Register-file writeback sequencer: turns ALU/LINK/LOAD completions into single-cycle write strobes.
module mips_cpu_writeback
    import mips_cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_kind,
    input  logic [4:0]  req_dest,
    input  logic [31:0] req_data,
    input  logic [2:0]  req_load_type,
    input  logic [1:0]  req_byte_off,
    input  logic [31:0] req_old_rt,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        reg_we,
    output logic [4:0]  reg_waddr,
    output logic [31:0] reg_wdata,
    output logic        busy,
    output logic        err
);

    localparam int               CTR_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CTR_W-1:0] CTR_LIMIT = CTR_W'(MEM_TIMEOUT);

    wb_state_t        state, state_nxt;
    logic [CTR_W-1:0] ctr, ctr_nxt, ctr_inc;
    logic [4:0]       cap_dest, cap_dest_nxt;
    load_type_t       cap_type, cap_type_nxt;
    logic [1:0]       cap_off, cap_off_nxt;
    logic [31:0]      cap_old, cap_old_nxt;
    logic             we_nxt, err_nxt;
    logic [4:0]       waddr_nxt;
    logic [31:0]      wdata_nxt;
    logic             accept;
    logic [31:0]      load_value;
    wb_kind_t         kind;

    assign req_ready = (state == ST_IDLE) || (state == ST_WRITE);
    assign busy      = (state != ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign kind      = wb_kind_t'(req_kind);
    assign ctr_inc   = ctr + CTR_W'(1);

    mips_cpu_load_extract u_extract (
        .rdata     (mem_rdata),
        .load_type (cap_type),
        .byte_off  (cap_off),
        .old_rt    (cap_old),
        .value     (load_value)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ctr       <= '0;
            cap_dest  <= '0;
            cap_type  <= LT_LB;
            cap_off   <= '0;
            cap_old   <= '0;
            reg_we    <= 1'b0;
            reg_waddr <= '0;
            reg_wdata <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            ctr       <= ctr_nxt;
            cap_dest  <= cap_dest_nxt;
            cap_type  <= cap_type_nxt;
            cap_off   <= cap_off_nxt;
            cap_old   <= cap_old_nxt;
            reg_we    <= we_nxt;
            reg_waddr <= waddr_nxt;
            reg_wdata <= wdata_nxt;
            err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ctr_nxt      = ctr;
        cap_dest_nxt = cap_dest;
        cap_type_nxt = cap_type;
        cap_off_nxt  = cap_off;
        cap_old_nxt  = cap_old;
        we_nxt       = 1'b0;
        waddr_nxt    = reg_waddr;
        wdata_nxt    = reg_wdata;
        err_nxt      = 1'b0;

        case (state)
            ST_IDLE, ST_WRITE: begin
                if (!accept) begin
                    state_nxt = ST_IDLE;
                end else if (kind == WB_LOAD) begin
                    state_nxt    = ST_WAIT_MEM;
                    ctr_nxt      = '0;
                    cap_dest_nxt = req_dest;
                    cap_type_nxt = load_type_t'(req_load_type);
                    cap_off_nxt  = req_byte_off;
                    cap_old_nxt  = req_old_rt;
                end else begin
                    // ALU, LINK and the reserved kind all write req_data directly
                    state_nxt = ST_WRITE;
                    we_nxt    = (req_dest != 5'd0);
                    waddr_nxt = req_dest;
                    wdata_nxt = req_data;
                end
            end
            ST_WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_nxt = ST_WRITE;
                    we_nxt    = (cap_dest != 5'd0);
                    waddr_nxt = cap_dest;
                    wdata_nxt = load_value;
                    err_nxt   = (cap_type == LT_RSVD);
                end else begin
                    ctr_nxt = ctr_inc;
                    if (ctr_inc == CTR_LIMIT) begin
                        state_nxt = ST_IDLE;
                        err_nxt   = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_cpu_writeback.sv
// Directed plus randomized bench for mips_cpu_writeback with a byte-level reference model of MIPS loads.
module tb_mips_cpu_writeback;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [4:0]  req_dest;
    logic [31:0] req_data;
    logic [2:0]  req_load_type;
    logic [1:0]  req_byte_off;
    logic [31:0] req_old_rt;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    mips_cpu_writeback #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_kind      (req_kind),
        .req_dest      (req_dest),
        .req_data      (req_data),
        .req_load_type (req_load_type),
        .req_byte_off  (req_byte_off),
        .req_old_rt    (req_old_rt),
        .mem_rdata     (mem_rdata),
        .mem_rvalid    (mem_rvalid),
        .reg_we        (reg_we),
        .reg_waddr     (reg_waddr),
        .reg_wdata     (reg_wdata),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: treat memory word and old rt as byte arrays and apply the MIPS load rules.
    function automatic logic [31:0] ref_load(input int t, input int k, input logic [31:0] old, input logic [31:0] rd);
        logic [7:0] m[4];
        logic [7:0] r[4];
        int v;
        int b;
        for (int i = 0; i < 4; i++) begin
            m[i] = rd[8*i +: 8];
            r[i] = old[8*i +: 8];
        end
        b = (k / 2) * 2;
        case (t)
            0: begin v = int'(m[k]); if (v >= 128) v -= 256; return 32'(v); end
            4: return 32'(int'(m[k]));
            1: begin v = int'(m[b]) + 256 * int'(m[b+1]); if (v >= 32768) v -= 65536; return 32'(v); end
            5: return 32'(int'(m[b]) + 256 * int'(m[b+1]));
            2: begin
                for (int i = 0; i <= k; i++) r[3-k+i] = m[i];
                return {r[3], r[2], r[1], r[0]};
            end
            6: begin
                for (int i = k; i < 4; i++) r[i-k] = m[i];
                return {r[3], r[2], r[1], r[0]};
            end
            default: return rd;
        endcase
    endfunction

    task automatic alu_req(input int kind, input logic [4:0] dest, input logic [31:0] data, input string tag);
        req_valid = 1'b1;
        req_kind  = 2'(kind);
        req_dest  = dest;
        req_data  = data;
        tick();
        req_valid = 1'b0;
        req_data  = $urandom;
        check({tag, "_we"}, reg_we, {31'b0, dest != 5'd0});
        check({tag, "_waddr"}, reg_waddr, dest);
        check({tag, "_wdata"}, reg_wdata, data);
        check({tag, "_err"}, err, 0);
        tick();
        mem_rvalid = 1'b0;
        check({tag, "_we_off"}, reg_we, 0);
        check({tag, "_ready"}, req_ready, 1);
    endtask

    task automatic load_req(input int t, input int k, input logic [4:0] dest, input logic [31:0] old,
                            input logic [31:0] rd, input int delay, input string tag);
        logic [31:0] exp;
        exp           = ref_load(t, k, old, rd);
        req_valid     = 1'b1;
        req_kind      = 2'd1;
        req_dest      = dest;
        req_load_type = 3'(t);
        req_byte_off  = 2'(k);
        req_old_rt    = old;
        req_data      = $urandom;
        tick();
        req_valid     = 1'b0;
        req_dest      = 5'($urandom);
        req_load_type = 3'($urandom);
        req_byte_off  = 2'($urandom);
        req_old_rt    = $urandom;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_notready"}, req_ready, 0);
        for (int i = 0; i < delay; i++) begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            tick();
            check({tag, "_wait_we"}, reg_we, 0);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        check({tag, "_we"}, reg_we, {31'b0, dest != 5'd0});
        check({tag, "_waddr"}, reg_waddr, dest);
        check({tag, "_wdata"}, reg_wdata, exp);
        check({tag, "_err"}, err, {31'b0, t == 7});
        tick();
        check({tag, "_we_off"}, reg_we, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int n;
        logic saw_write;
        reset = 1'b1; req_valid = 1'b0; req_kind = '0; req_dest = '0; req_data = '0;
        req_load_type = '0; req_byte_off = '0; req_old_rt = '0; mem_rdata = '0; mem_rvalid = 1'b0;
        tick();
        tick();
        check("rst_we", reg_we, 0);
        check("rst_waddr", reg_waddr, 0);
        check("rst_wdata", reg_wdata, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 1);
        reset = 1'b0;
        tick();

        alu_req(0, 5'd2, 32'hDEADBEEF, "alu_basic");
        alu_req(2, 5'd31, 32'h0040_0108, "link");
        alu_req(3, 5'd9, 32'h0BADF00D, "kind_rsvd");

        // three ALU writes back to back
        for (int i = 3; i <= 5; i++) begin
            check("b2b_ready_pre", req_ready, 1);
            req_valid = 1'b1; req_kind = 2'd0; req_dest = 5'(i); req_data = 32'h1000 + 32'(i);
            tick();
            check("b2b_we", reg_we, 1);
            check("b2b_waddr", reg_waddr, 32'(i));
            check("b2b_wdata", reg_wdata, 32'h1000 + 32'(i));
            check("b2b_ready", req_ready, 1);
        end
        req_valid = 1'b0;
        tick();
        check("b2b_end_we", reg_we, 0);

        req_valid = 1'b1; req_kind = 2'd0; req_dest = 5'd0; req_data = 32'h12345678;
        tick();
        req_valid = 1'b0;
        check("r0_we", reg_we, 0);
        check("r0_busy", busy, 1);
        tick();
        check("r0_ready", req_ready, 1);
        check("r0_we2", reg_we, 0);

        load_req(0, 2, 5'd8, 32'h0, 32'h80FF7F00, 1, "lb");
        load_req(4, 2, 5'd8, 32'h0, 32'h80FF7F00, 0, "lbu");
        load_req(1, 2, 5'd8, 32'h0, 32'h80FF7F00, 2, "lh");
        load_req(5, 3, 5'd8, 32'h0, 32'h80FF7F00, 0, "lhu");
        load_req(3, 1, 5'd10, 32'h0, 32'hCAFEF00D, 3, "lw");
        load_req(2, 1, 5'd11, 32'hAABBCCDD, 32'h44332211, 0, "lwl");
        load_req(6, 2, 5'd11, 32'hAABBCCDD, 32'h44332211, 1, "lwr");
        load_req(7, 0, 5'd12, 32'h0, 32'h5A5AA5A5, 0, "rsvd");
        load_req(3, 0, 5'd0, 32'h0, 32'h11112222, 0, "load_r0");

        // ALU write followed immediately by a load accepted in WRITE
        req_valid = 1'b1; req_kind = 2'd0; req_dest = 5'd7; req_data = 32'h77;
        tick();
        check("mix_alu_we", reg_we, 1);
        req_kind = 2'd1; req_dest = 5'd13; req_load_type = 3'd3; req_byte_off = 2'd0;
        tick();
        req_valid = 1'b0;
        check("mix_wait_we", reg_we, 0);
        check("mix_wait_busy", busy, 1);
        mem_rvalid = 1'b1; mem_rdata = 32'h13131313;
        tick();
        mem_rvalid = 1'b0;
        check("mix_load_waddr", reg_waddr, 13);
        check("mix_load_wdata", reg_wdata, 32'h13131313);
        tick();

        // memory never answers
        req_valid = 1'b1; req_kind = 2'd1; req_dest = 5'd14; req_load_type = 3'd3;
        tick();
        req_valid = 1'b0;
        n = 0; saw_write = 1'b0;
        while (err !== 1'b1 && n < TIMEOUT + 20) begin
            tick();
            n++;
            if (reg_we === 1'b1) saw_write = 1'b1;
        end
        check("timeout_cycles", 32'(n), TIMEOUT);
        check("timeout_nowrite", {31'b0, saw_write}, 0);
        check("timeout_idle", busy, 0);
        tick();
        check("timeout_err_pulse", err, 0);

        // reset while waiting on memory, with rvalid arriving on the same edge
        req_valid = 1'b1; req_kind = 2'd1; req_dest = 5'd15; req_load_type = 3'd3;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFEEDFACE;
        tick();
        check("rstw_we", reg_we, 0);
        check("rstw_busy", busy, 0);
        check("rstw_waddr", reg_waddr, 0);
        reset = 1'b0;
        tick();
        mem_rvalid = 1'b0;
        check("rstw_after_we", reg_we, 0);
        check("rstw_after_busy", busy, 0);

        for (int it = 0; it < 150; it++) begin
            int kind;
            mem_rvalid = 1'($urandom);
            mem_rdata  = $urandom;
            kind = $urandom_range(0, 3);
            if (kind == 1)
                load_req($urandom_range(0, 7), $urandom_range(0, 3), 5'($urandom), $urandom, $urandom,
                         $urandom_range(0, 6), "rnd_load");
            else
                alu_req(kind, 5'($urandom), $urandom, "rnd_alu");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
